// File: rtl/instr_encoder_pkg.sv
// Mnemonic enum, MIPS opcode/funct constants and field-packing helpers for instr_encoder.
package enc_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_SLT, OP_SLTU, OP_SLL, OP_SLLV, OP_SRL, OP_SRLV,
    OP_SRA, OP_SRAV, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_JR, OP_JALR,
    OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_LUI,
    OP_LB, OP_SB, OP_LBU, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLTZ,
    OP_BGEZ, OP_BGTZ, OP_BLEZ, OP_NOP
  } enc_op_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A, OPC_SLTIU  = 6'h0B, OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E, OPC_LUI    = 6'h0F, OPC_LB   = 6'h20;
  localparam logic [5:0] OPC_LW      = 6'h23, OPC_LBU    = 6'h24, OPC_SB   = 6'h28;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MFLO  = 6'h12, FN_MULT = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  function automatic logic is_branch_or_jump(input logic [5:0] op);
    case (op)
      OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE,
      OP_BLTZ, OP_BGEZ, OP_BGTZ, OP_BLEZ: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input logic [5:0] op);
    case (op)
      OP_ADD:  return FN_ADD;   OP_ADDU:  return FN_ADDU;  OP_SUB:  return FN_SUB;
      OP_SUBU: return FN_SUBU;  OP_MULT:  return FN_MULT;  OP_MULTU: return FN_MULTU;
      OP_DIV:  return FN_DIV;   OP_DIVU:  return FN_DIVU;  OP_MFHI: return FN_MFHI;
      OP_MFLO: return FN_MFLO;  OP_SLT:   return FN_SLT;   OP_SLTU: return FN_SLTU;
      OP_SLL:  return FN_SLL;   OP_SLLV:  return FN_SLLV;  OP_SRL:  return FN_SRL;
      OP_SRLV: return FN_SRLV;  OP_SRA:   return FN_SRA;   OP_SRAV: return FN_SRAV;
      OP_AND:  return FN_AND;   OP_OR:    return FN_OR;    OP_XOR:  return FN_XOR;
      OP_NOR:  return FN_NOR;   OP_JR:    return FN_JR;    OP_JALR: return FN_JALR;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input logic [5:0] op);
    case (op)
      OP_ADDIU: return OPC_ADDIU; OP_SLTI: return OPC_SLTI; OP_SLTIU: return OPC_SLTIU;
      OP_ORI:   return OPC_ORI;   OP_XORI: return OPC_XORI; OP_LW:   return OPC_LW;
      OP_SW:    return OPC_SW;    OP_LUI:  return OPC_LUI;  OP_LB:   return OPC_LB;
      OP_SB:    return OPC_SB;    OP_LBU:  return OPC_LBU;  OP_J:    return OPC_J;
      OP_JAL:   return OPC_JAL;   OP_BEQ:  return OPC_BEQ;  OP_BNE:  return OPC_BNE;
      OP_BLTZ:  return OPC_REGIMM; OP_BGEZ: return OPC_REGIMM;
      OP_BGTZ:  return OPC_BGTZ;  OP_BLEZ: return OPC_BLEZ;
      default:  return OPC_SPECIAL;
    endcase
  endfunction

  function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {OPC_SPECIAL, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of instr_encoder.
interface instr_encoder_if #(parameter int CNT_W = 11);
  logic             op_valid;
  logic             op_ready;
  logic [5:0]       op_code;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       sa;
  logic [15:0]      imm16;
  logic [25:0]      target26;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_busy;
  logic [CNT_W-1:0] word_count;
  logic             full;
  logic             err;

  modport master (
    output op_valid, op_code, rs, rt, rd, sa, imm16, target26, mem_busy,
    input  op_ready, mem_we, mem_addr, mem_wdata, word_count, full, err
  );

  modport slave (
    input  op_valid, op_code, rs, rt, rd, sa, imm16, target26, mem_busy,
    output op_ready, mem_we, mem_addr, mem_wdata, word_count, full, err
  );
endinterface

// File: rtl/instr_encoder_mips_word_pack.sv
// Combinational mnemonic+fields -> 32-bit MIPS word; vld_o low for codes outside enc_op_t.
module mips_word_pack
  import enc_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  sa_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] target26_i,
  output logic [31:0] word_o,
  output logic        vld_o
);

  logic [5:0] fn;
  logic [5:0] opc;

  assign fn  = funct_of(op_i);
  assign opc = opcode_of(op_i);

  always_comb begin
    word_o = '0;
    vld_o  = 1'b1;
    case (op_i)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SLLV, OP_SRLV, OP_SRAV:
        word_o = r_word(rs_i, rt_i, rd_i, 5'd0, fn);
      OP_SLL, OP_SRL, OP_SRA:
        word_o = r_word(5'd0, rt_i, rd_i, sa_i, fn);
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
        word_o = r_word(rs_i, rt_i, 5'd0, 5'd0, fn);
      OP_MFHI, OP_MFLO:
        word_o = r_word(5'd0, 5'd0, rd_i, 5'd0, fn);
      OP_JR:
        word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, fn);
      OP_JALR:
        word_o = r_word(rs_i, 5'd0, rd_i, 5'd0, fn);
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LW, OP_SW,
      OP_LB, OP_SB, OP_LBU, OP_BEQ, OP_BNE:
        word_o = i_word(opc, rs_i, rt_i, imm16_i);
      OP_LUI:
        word_o = i_word(opc, 5'd0, rt_i, imm16_i);
      // REGIMM branches select the condition through the rt field
      OP_BLTZ:
        word_o = i_word(opc, rs_i, 5'd0, imm16_i);
      OP_BGEZ:
        word_o = i_word(opc, rs_i, 5'd1, imm16_i);
      OP_BGTZ, OP_BLEZ:
        word_o = i_word(opc, rs_i, 5'd0, imm16_i);
      OP_J, OP_JAL:
        word_o = {opc, target26_i};
      OP_NOP:
        word_o = 32'h0;
      default:
        vld_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded field bundles into MIPS words and writes them sequentially to instruction memory.
// ENCODER_DELAY_SLOT_PAD_EN: follow each branch/jump with a NOP delay-slot word when room remains.
module instr_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = 11
) (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  instr_encoder_if.slave   bus
);

`ifdef ENCODER_DELAY_SLOT_PAD_EN
  typedef enum logic [1:0] {IDLE, PACK, WRITE, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;
`endif

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state_q;
  logic [5:0]       op_q;
  logic [4:0]       rs_q, rt_q, rd_q, sa_q;
  logic [15:0]      imm_q;
  logic [25:0]      tgt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic [31:0]      word_d;
  logic             word_vld;
  logic             full;
  logic             op_ready;

  mips_word_pack u_pack (
    .op_i       (op_q),
    .rs_i       (rs_q),
    .rt_i       (rt_q),
    .rd_i       (rd_q),
    .sa_i       (sa_q),
    .imm16_i    (imm_q),
    .target26_i (tgt_q),
    .word_o     (word_d),
    .vld_o      (word_vld)
  );

  assign full     = (count_q == DEPTH_C);
  assign op_ready = (state_q == IDLE) && !full && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid && op_ready) begin
            op_q    <= bus.op_code;
            rs_q    <= bus.rs;
            rt_q    <= bus.rt;
            rd_q    <= bus.rd;
            sa_q    <= bus.sa;
            imm_q   <= bus.imm16;
            tgt_q   <= bus.target26;
            state_q <= PACK;
          end
        end
        PACK: begin
          if (!word_vld) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdata_q <= word_d;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!bus.mem_busy) begin
            addr_q  <= addr_q + 32'd4;
            count_q <= count_q + CNT_W'(1);
`ifdef ENCODER_DELAY_SLOT_PAD_EN
            // Pad only when a slot is left after the branch itself
            if (is_branch_or_jump(op_q) && (count_q + CNT_W'(1) != DEPTH_C)) begin
              wdata_q <= 32'h0;
              state_q <= PAD;
            end else begin
              we_q    <= 1'b0;
              state_q <= IDLE;
            end
`else
            we_q    <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
`ifdef ENCODER_DELAY_SLOT_PAD_EN
        PAD: begin
          if (!bus.mem_busy) begin
            addr_q  <= addr_q + 32'd4;
            count_q <= count_q + CNT_W'(1);
            we_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_ready   = op_ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.word_count = count_q;
  assign bus.full       = full;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized bundles against a table-driven encoding model.
`timescale 1ns/1ps
module tb_instr_encoder;
  import enc_pkg::*;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 4;
  localparam int          CNT_W = 11;

  logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic busy_man = 1'b0, busy_rnd = 1'b0, stall_en = 1'b0;
  int   errors = 0, checks = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  int          exp_count = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_addr = BASE;

  instr_encoder_if #(.CNT_W(CNT_W)) bus();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus)
  );

  assign bus.mem_busy = busy_man | (stall_en & busy_rnd);

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    busy_rnd = ($urandom_range(0, 2) == 0);
  end

  // Every committed write: strobe high and memory not stalled at the closing edge
  always @(negedge clock)
    if (!reset && !flush && bus.mem_we && !bus.mem_busy)
      obs_q.push_back({bus.mem_addr, bus.mem_wdata});

  // Encoding model: per-mnemonic opcode/funct and which fields survive, summed arithmetically
  function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [4:0] rs, rt, rd, sa,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned opc = 0, fn = 0, w = 0, f_rs, f_rt, f_rd, f_sa;
    int          kind = 0, frt = -1;
    logic [3:0]  m = 4'b0000;
    case (op)
      OP_ADD:   begin fn = 32; m = 4'b1110; end
      OP_ADDU:  begin fn = 33; m = 4'b1110; end
      OP_SUB:   begin fn = 34; m = 4'b1110; end
      OP_SUBU:  begin fn = 35; m = 4'b1110; end
      OP_MULT:  begin fn = 24; m = 4'b1100; end
      OP_MULTU: begin fn = 25; m = 4'b1100; end
      OP_DIV:   begin fn = 26; m = 4'b1100; end
      OP_DIVU:  begin fn = 27; m = 4'b1100; end
      OP_MFHI:  begin fn = 16; m = 4'b0010; end
      OP_MFLO:  begin fn = 18; m = 4'b0010; end
      OP_SLT:   begin fn = 42; m = 4'b1110; end
      OP_SLTU:  begin fn = 43; m = 4'b1110; end
      OP_SLL:   begin fn = 0;  m = 4'b0111; end
      OP_SLLV:  begin fn = 4;  m = 4'b1110; end
      OP_SRL:   begin fn = 2;  m = 4'b0111; end
      OP_SRLV:  begin fn = 6;  m = 4'b1110; end
      OP_SRA:   begin fn = 3;  m = 4'b0111; end
      OP_SRAV:  begin fn = 7;  m = 4'b1110; end
      OP_AND:   begin fn = 36; m = 4'b1110; end
      OP_OR:    begin fn = 37; m = 4'b1110; end
      OP_XOR:   begin fn = 38; m = 4'b1110; end
      OP_NOR:   begin fn = 39; m = 4'b1110; end
      OP_JR:    begin fn = 8;  m = 4'b1000; end
      OP_JALR:  begin fn = 9;  m = 4'b1010; end
      OP_ADDIU: begin kind = 1; opc = 9;  m = 4'b1100; end
      OP_SLTI:  begin kind = 1; opc = 10; m = 4'b1100; end
      OP_SLTIU: begin kind = 1; opc = 11; m = 4'b1100; end
      OP_ORI:   begin kind = 1; opc = 13; m = 4'b1100; end
      OP_XORI:  begin kind = 1; opc = 14; m = 4'b1100; end
      OP_LW:    begin kind = 1; opc = 35; m = 4'b1100; end
      OP_SW:    begin kind = 1; opc = 43; m = 4'b1100; end
      OP_LUI:   begin kind = 1; opc = 15; m = 4'b0100; end
      OP_LB:    begin kind = 1; opc = 32; m = 4'b1100; end
      OP_SB:    begin kind = 1; opc = 40; m = 4'b1100; end
      OP_LBU:   begin kind = 1; opc = 36; m = 4'b1100; end
      OP_BEQ:   begin kind = 1; opc = 4;  m = 4'b1100; end
      OP_BNE:   begin kind = 1; opc = 5;  m = 4'b1100; end
      OP_BLTZ:  begin kind = 1; opc = 1;  m = 4'b1000; frt = 0; end
      OP_BGEZ:  begin kind = 1; opc = 1;  m = 4'b1000; frt = 1; end
      OP_BGTZ:  begin kind = 1; opc = 7;  m = 4'b1000; end
      OP_BLEZ:  begin kind = 1; opc = 6;  m = 4'b1000; end
      OP_J:     begin kind = 2; opc = 2; end
      OP_JAL:   begin kind = 2; opc = 3; end
      OP_NOP:   kind = 3;
      default:  return {1'b0, 32'h0};
    endcase
    f_rs = m[3] ? 32'(rs) : 0;
    f_rt = (frt >= 0) ? 32'(frt) : (m[2] ? 32'(rt) : 0);
    f_rd = m[1] ? 32'(rd) : 0;
    f_sa = m[0] ? 32'(sa) : 0;
    case (kind)
      0:       w = f_rs * 32'd2097152 + f_rt * 32'd65536 + f_rd * 32'd2048 + f_sa * 32'd64 + fn;
      1:       w = opc * 32'd67108864 + f_rs * 32'd2097152 + f_rt * 32'd65536 + 32'(imm);
      2:       w = opc * 32'd67108864 + 32'(tgt);
      default: w = 0;
    endcase
    return {1'b1, w};
  endfunction

  function automatic bit ref_is_br(input logic [5:0] op);
    return op inside {OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BLTZ, OP_BGEZ, OP_BGTZ, OP_BLEZ};
  endfunction

  task automatic model_apply(input logic [5:0] op, input logic [4:0] rs, rt, rd, sa,
                             input logic [15:0] imm, input logic [25:0] tgt);
    logic [32:0] r;
    r = ref_encode(op, rs, rt, rd, sa, imm, tgt);
    if (exp_count == DEPTH) return;
    if (!r[32]) begin exp_err = 1'b1; return; end
    exp_q.push_back({exp_addr, r[31:0]});
    exp_addr += 32'd4;
    exp_count++;
`ifdef ENCODER_DELAY_SLOT_PAD_EN
    if (ref_is_br(op) && exp_count < DEPTH) begin
      exp_q.push_back({exp_addr, 32'h0});
      exp_addr += 32'd4;
      exp_count++;
    end
`endif
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, rt, rd, sa,
                      input logic [15:0] imm, input logic [25:0] tgt);
    bit acc = 0;
    @(posedge clock); #1;
    bus.op_valid = 1'b1; bus.op_code = op; bus.rs = rs; bus.rt = rt; bus.rd = rd;
    bus.sa = sa; bus.imm16 = imm; bus.target26 = tgt;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clock);
      if (bus.op_ready) begin
        @(posedge clock); #1;
        acc = 1;
      end
    end
    bus.op_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL accept_timeout: op_ready never seen, required within 30 cycles"); end
  endtask

  task automatic wait_done;
    bit done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clock);
      if (k >= 2 && !bus.mem_we) done = 1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL done_timeout: mem_we still 1 after 60 cycles, required 0"); end
  endtask

  task automatic do_flush;
    @(posedge clock); #1; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_count = 0; exp_addr = BASE; exp_err = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_during: got %b want 0", bus.op_ready); end
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", bus.op_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== BASE) begin errors++; $display("FAIL rst_addr: got %h want %h", bus.mem_addr, BASE); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.word_count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.word_count); end
    checks++; if (bus.full !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_full_err: got %b%b want 00", bus.full, bus.err); end
  endtask

  task automatic test_addu_latency;
    send(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clock);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL lat_pack_we: got %b want 0", bus.mem_we); end
    @(negedge clock);
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL lat_write_we: got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_addr !== BASE || bus.mem_wdata !== 32'h0022_1821) begin
      errors++; $display("FAIL addu_word: got %h@%h want 00221821@%h", bus.mem_wdata, bus.mem_addr, BASE); end
    @(negedge clock);
    checks++; if (bus.word_count !== CNT_W'(1) || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL addu_count: got cnt=%0d we=%b want cnt=1 we=0", bus.word_count, bus.mem_we); end
  endtask

  task automatic test_sequence;
    logic [31:0] want [4];
    want = '{32'h2405_1234, 32'h8FA8_FFFC, 32'h0004_10C0, 32'h04E1_0004};
    do_flush();
    send(OP_ADDIU, 5'd0, 5'd5, 5'd31, 5'd7, 16'h1234, 26'h3FF_FFFF); wait_done();
    send(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0); wait_done();
    send(OP_SLL, 5'd9, 5'd4, 5'd2, 5'd3, 16'hAAAA, 26'h0); wait_done();
    send(OP_BGEZ, 5'd7, 5'd5, 5'd12, 5'd0, 16'h0004, 26'h0); wait_done();
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL seq_len: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {BASE + 32'(4 * i), want[i]}) begin
        errors++; $display("FAIL seq_word%0d: got %h want %h", i, obs_q[i], {BASE + 32'(4 * i), want[i]}); end
    end
    checks++; if (bus.full !== 1'b1 || bus.op_ready !== 1'b0) begin
      errors++; $display("FAIL seq_full: got full=%b rdy=%b want 1 0", bus.full, bus.op_ready); end
  endtask

  task automatic test_full;
    bit bad = 0;
    @(posedge clock); #1;
    bus.op_valid = 1'b1; bus.op_code = OP_ADDU;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.op_ready !== 1'b0 || bus.mem_we !== 1'b0) bad = 1;
    end
    bus.op_valid = 1'b0;
    checks++; if (bad || bus.word_count !== CNT_W'(4) || obs_q.size() != 4) begin
      errors++; $display("FAIL full_ignore: got cnt=%0d writes=%0d bad=%0d want 4 4 0", bus.word_count, obs_q.size(), bad); end
    do_flush();
    @(negedge clock);
    checks++; if (bus.word_count !== '0 || bus.full !== 1'b0 || bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got cnt=%0d full=%b rdy=%b want 0 0 1", bus.word_count, bus.full, bus.op_ready); end
    send(OP_NOP, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1, 26'h1); wait_done();
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {BASE, 32'h0}) begin
      errors++; $display("FAIL flush_restart: got n=%0d first=%h want 1 %h", obs_q.size(), obs_q.size() ? obs_q[0] : 64'h0, {BASE, 32'h0}); end
  endtask

  task automatic test_stall;
    logic [31:0] a0 = 0, d0 = 0;
    int we_cycles = 0;
    bit unstable = 0, fin = 0;
    do_flush();
    busy_man = 1'b1;
    send(OP_ORI, 5'd3, 5'd4, 5'd9, 5'd9, 16'hBEEF, 26'h0);
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clock);
      if (bus.mem_we) begin
        if (we_cycles == 0) begin a0 = bus.mem_addr; d0 = bus.mem_wdata; end
        else if (bus.mem_addr !== a0 || bus.mem_wdata !== d0) unstable = 1;
        we_cycles++;
        if (we_cycles == 3) begin @(posedge clock); #1; busy_man = 1'b0; end
      end else if (we_cycles > 0) fin = 1;
    end
    busy_man = 1'b0;
    checks++; if (we_cycles != 4 || unstable) begin
      errors++; $display("FAIL stall_hold: got we_cycles=%0d unstable=%0d want 4 0", we_cycles, unstable); end
    checks++; if (obs_q.size() != 1 || bus.word_count !== CNT_W'(1)) begin
      errors++; $display("FAIL stall_commit: got writes=%0d cnt=%0d want 1 1", obs_q.size(), bus.word_count); end
    checks++; if (d0 !== 32'h3464_BEEF || a0 !== BASE) begin
      errors++; $display("FAIL stall_word: got %h@%h want 3464beef@%h", d0, a0, BASE); end
  endtask

  task automatic test_invalid;
    do_flush();
    send(6'd50, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6); wait_done();
    checks++; if (bus.err !== 1'b1 || obs_q.size() != 0 || bus.word_count !== '0) begin
      errors++; $display("FAIL invalid_op: got err=%b writes=%0d cnt=%0d want 1 0 0", bus.err, obs_q.size(), bus.word_count); end
    send(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0); wait_done();
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {BASE, 32'h0022_1821} || bus.err !== 1'b1) begin
      errors++; $display("FAIL invalid_addr: got n=%0d err=%b want first write at base, err sticky", obs_q.size(), bus.err); end
    do_flush();
    @(negedge clock);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", bus.err); end
  endtask

  task automatic test_pad;
    do_flush();
    send(OP_J, 5'd4, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h10); wait_done();
`ifdef ENCODER_DELAY_SLOT_PAD_EN
    checks++; if (obs_q.size() != 2 || obs_q[0] !== {BASE, 32'h0800_0010} || obs_q[1] !== {BASE + 32'd4, 32'h0}
                  || bus.word_count !== CNT_W'(2)) begin
      errors++; $display("FAIL pad_j: got n=%0d cnt=%0d want J word then NOP, cnt=2", obs_q.size(), bus.word_count); end
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0); wait_done();
`else
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {BASE, 32'h0800_0010} || bus.word_count !== CNT_W'(1)) begin
      errors++; $display("FAIL pad_j: got n=%0d cnt=%0d want single J word, cnt=1", obs_q.size(), bus.word_count); end
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0); wait_done();
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0); wait_done();
`endif
    // Branch into the last slot: written, no pad, block full
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0008, 26'h0); wait_done();
    checks++; if (obs_q.size() != 4 || obs_q[3] !== {BASE + 32'd12, 32'h1022_0008} || bus.full !== 1'b1) begin
      errors++; $display("FAIL pad_last_slot: got n=%0d full=%b want 4 writes, BEQ at base+12, full", obs_q.size(), bus.full); end
  endtask

  task automatic test_random;
    logic [5:0] op; logic [4:0] rs, rt, rd, sa; logic [15:0] imm; logic [25:0] tgt;
    logic [63:0] e;
    do_flush();
    stall_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_count == DEPTH) do_flush();
      op = 6'($urandom_range(0, 47));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
      imm = 16'($urandom); tgt = 26'($urandom);
      model_apply(op, rs, rt, rd, sa, imm, tgt);
      send(op, rs, rt, rd, sa, imm, tgt); wait_done();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_count%0d: op=%0d got %0d writes want %0d", i, op, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q[0] !== e) begin errors++; $display("FAIL rnd_word%0d: op=%0d got %h want %h", i, op, obs_q[0], e); end
        void'(obs_q.pop_front());
      end
      obs_q.delete(); exp_q.delete();
      checks++;
      if (bus.err !== exp_err || bus.word_count !== CNT_W'(exp_count)) begin
        errors++; $display("FAIL rnd_state%0d: got err=%b cnt=%0d want %b %0d", i, bus.err, bus.word_count, exp_err, exp_count);
      end
    end
    stall_en = 1'b0;
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_code = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.sa = '0; bus.imm16 = '0; bus.target26 = '0;
    test_reset();
    test_addu_latency();
    test_sequence();
    test_full();
    test_stall();
    test_invalid();
    test_pad();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (mnemonic class, register numbers, shift amount, immediate/offset, jump target) over a valid/ready handshake and packs them into 32-bit MIPS instruction words. Writes each word sequentially into instruction memory through a single write port. Used by benches and the boot loader to build programs that the fetch/decode path then executes.

Parameters:
BASE_ADDR, 32'h8002_0000, byte address of the first word written; must be word-aligned
DEPTH, 1024, maximum number of words written before the block reports full
CNT_W, 11, width of the word counter; must satisfy 2**CNT_W > DEPTH

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous restart: counter and address return to base, err cleared
op_valid  input  1  field bundle valid
op_ready  output  1  block can accept a bundle
op_code  input  6  mnemonic enum (enc_op_t)
rs  input  5  source register / base
rt  input  5  target register
rd  input  5  destination register
sa  input  5  shift amount
imm16  input  16  immediate or branch/memory offset
target26  input  26  J/JAL target field
mem_we  output  1  memory write strobe
mem_addr  output  32  byte address of the write
mem_wdata  output  32  encoded instruction word
mem_busy  input  1  memory stall; the write is held while high
word_count  output  CNT_W  number of words committed since reset/flush
full  output  1  word_count == DEPTH
err  output  1  sticky flag: an unsupported op_code was received

Behaviour:
- Reset values: op_ready=0 during reset, 1 in the first cycle after; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err=0; FSM in IDLE.
- FSM states: IDLE, PACK, WRITE.
- IDLE: op_ready = !full. On op_valid&&op_ready, register all fields and go to PACK.
- PACK (1 cycle): pack the registered fields into a word register.
  - Invalid op_code: set err, discard the bundle, return to IDLE, no write.
  - Otherwise go to WRITE.
- WRITE: mem_we=1 with mem_addr and mem_wdata stable.
  - If mem_busy=1, stay in WRITE with all outputs unchanged.
  - If mem_busy=0, the write commits this cycle. On the next edge: mem_addr += 4, word_count += 1, return to IDLE.
- Latency: a bundle accepted at edge N gives mem_we=1 in cycle N+2 when there is no stall. Throughput is one word per 3 cycles.
- Encoding rules:
  - R-type: opcode 0, funct per mnemonic; unused fields zero.
  - SLL/SRL/SRA place sa in [10:6] and rs=0.
  - MULT/DIV leave rd=0. MFHI/MFLO use rd only. JR uses rs only. JALR uses rd and rs.
  - I-type: {opcode, rs, rt, imm16}. LUI forces rs=0.
  - BLTZ/BGEZ: opcode 1, rt forced to 0/1 respectively.
  - BGTZ/BLEZ force rt=0.
  - J/JAL: {opcode, target26}.
  - NOP: 32'h0.
- full: asserted when word_count==DEPTH. op_ready is held 0 until flush or reset. mem_addr wraps modulo 2^32, which cannot occur with legal parameters.
- flush: takes priority over every state. An in-flight write is abandoned (mem_we drops the next cycle). mem_addr=BASE_ADDR, word_count=0, err=0, state=IDLE.
- reset mid-operation behaves identically to flush, plus mem_wdata=0.
- op_valid while op_ready=0 is ignored; the source must hold the bundle until it is accepted.

Optional Feature:
ENCODER_DELAY_SLOT_PAD_EN
- Defined: after committing any J, JAL, JR, JALR, BEQ, BNE, BLTZ, BGEZ, BGTZ or BLEZ word, the FSM writes an extra NOP (32'h0) at the next address before returning to IDLE. This uses an additional PAD state and obeys the same mem_busy hold. word_count increments for both words. If only one slot remains before full, the branch is written and the pad is dropped; full then asserts.
- Undefined: no padding; PAD state absent.

Decomposition:
- Package enc_pkg:
  - enc_op_t enum covering ADD, ADDU, SUB, SUBU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, SLT, SLTU, SLL, SLLV, SRL, SRLV, SRA, SRAV, AND, OR, XOR, NOR, JR, JALR, ADDIU, SLTI, SLTIU, ORI, XORI, LW, SW, LUI, LB, SB, LBU, J, JAL, BEQ, BNE, BLTZ, BGEZ, BGTZ, BLEZ, NOP.
  - Opcode constants and funct constants.
  - is_branch_or_jump function.
- Sub-module mips_word_pack: purely combinational field-to-word packer with a valid output. The FSM stays in instr_encoder.

Test Plan:
- ADDU rd=3 rs=1 rt=2 after reset -> mem_we at cycle 2 after acceptance, mem_addr=0x80020000, mem_wdata=0x00221821, word_count=1.
- Consecutive ADDIU rt=5 rs=0 imm=0x1234; LW rt=8 rs=29 imm=0xFFFC; SLL rd=2 rt=4 sa=3; BGEZ rs=7 imm=0x0004 -> 0x24051234, 0x8FA8FFFC, 0x000410C0, 0x04E10004 at addresses 0x80020000..0x8002000C.
- mem_busy high for 3 cycles during WRITE -> mem_we held 4 cycles, address and data stable, word_count increments once.
- DEPTH=4: write 4 words -> full=1, op_ready=0, a fifth op_valid is ignored; flush -> word_count=0, next write at 0x80020000.
- op_code outside the enum -> err=1, no mem_we, address unchanged; flush clears err.
- With ENCODER_DELAY_SLOT_PAD_EN, J target26=0x10 -> 0x08000010 at base, 0x00000000 at base+4, word_count=2. Without the macro -> single word only.
